// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the BCD accumulator.
//               - state_t : accumulator FSM state encoding (IDLE/ACCUM/DONE)
//               - BCD_MAX : largest legal BCD digit value
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_accumulator_if
// Description : Digit-in / result-out handshake bundle for bcd_accumulator.
//               Digit side : digit_valid, digit[3:0], digit_last -> digit_ready
//               Result side: value, value_valid, err, ndig <- value_ready
//               Modport slave  : the accumulator.
//               Modport master : the digit source / result sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_accumulator_if #(
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14
);
    localparam int NDIG_W = $clog2(NDIGITS + 1);

    logic              digit_valid;
    logic [3:0]        digit;
    logic              digit_last;
    logic              digit_ready;
    logic [BIN_W-1:0]  value;
    logic              value_valid;
    logic              value_ready;
    logic              err;
    logic [NDIG_W-1:0] ndig;

    modport slave (
        input  digit_valid, digit, digit_last, value_ready,
        output digit_ready, value, value_valid, err, ndig
    );

    modport master (
        output digit_valid, digit, digit_last, value_ready,
        input  digit_ready, value, value_valid, err, ndig
    );

endinterface : bcd_accumulator_if
`default_nettype wire

// File: rtl/bcd_mac10.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mac10
// Description : Combinational multiply-by-ten-and-add. Computes
//               acc*10 + digit as (acc<<3) + (acc<<1) + digit, truncated to
//               BIN_W bits.
//   acc_i   [BIN_W-1:0] : current accumulator
//   digit_i [3:0]       : digit to append
//   acc_o   [BIN_W-1:0] : acc_i*10 + digit_i
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mac10 #(
    parameter int BIN_W = 14
) (
    input  wire logic [BIN_W-1:0] acc_i,
    input  wire logic [3:0]       digit_i,
    output logic      [BIN_W-1:0] acc_o
);

    logic [BIN_W-1:0] w_x8;
    logic [BIN_W-1:0] w_x2;

    assign w_x8  = acc_i << 3;
    assign w_x2  = acc_i << 1;
    assign acc_o = w_x8 + w_x2 + BIN_W'(digit_i);

endmodule : bcd_mac10
`default_nettype wire

// File: rtl/bcd_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : bcd_accumulator
// Description : Accepts a stream of BCD digits (MSD first) and accumulates
//               their binary value. The number ends on a digit flagged last;
//               the result is then held on the result side until taken.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bcd_accumulator_if.slave (digit input + result output handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_accumulator
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bcd_accumulator_if.slave   bus
);

    localparam int NDIG_W = $clog2(NDIGITS + 1);

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  acc_q,   acc_d;
    logic [NDIG_W-1:0] ndig_q,  ndig_d;
    logic              err_q,   err_d;

    logic              w_accept;
    logic [BIN_W-1:0]  w_mac;

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac10 (
        .acc_i   (acc_q),
        .digit_i (bus.digit),
        .acc_o   (w_mac)
    );

    assign bus.digit_ready = (state_q != DONE);
    assign bus.value_valid = (state_q == DONE);
    assign bus.value       = acc_q;
    assign bus.ndig        = ndig_q;
    assign bus.err         = err_q;

    assign w_accept = bus.digit_valid && bus.digit_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ndig_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ndig_q  <= ndig_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ndig_d  = ndig_q;
        err_d   = err_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    // A surplus digit is flagged but neither counted nor
                    // accumulated; an out-of-range digit is counted only.
                    if (ndig_q == NDIG_W'(NDIGITS)) begin
                        err_d = 1'b1;
                    end else if (bus.digit > BCD_MAX) begin
                        err_d  = 1'b1;
                        ndig_d = ndig_q + NDIG_W'(1);
                    end else begin
                        acc_d  = w_mac;
                        ndig_d = ndig_q + NDIG_W'(1);
                    end
                    state_d = bus.digit_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (bus.value_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    ndig_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                ndig_d  = '0;
                err_d   = 1'b0;
            end
        endcase
    end

endmodule : bcd_accumulator
`default_nettype wire

// File: tb/tb_bcd_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_accumulator
// Description : Directed self-checking bench for bcd_accumulator
//               (NDIGITS=4, BIN_W=14).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_accumulator;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bcd_accumulator_if #(.NDIGITS(4), .BIN_W(14)) bus ();

    bcd_accumulator #(
        .NDIGITS (4),
        .BIN_W   (14)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one digit and hold it until accepted (bounded wait).
    task automatic send_digit(input logic [3:0] d, input logic last);
        int n;
        n = 0;
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        bus.digit_last  = last;
        while (!bus.digit_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.digit_ready) begin
            checks++; failures++;
            $display("FAIL send_digit_timeout: digit_ready=%0b required=1", bus.digit_ready);
        end
        @(posedge clk); #1;
        bus.digit_valid = 1'b0;
        bus.digit_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.value_valid !== 1'b0) begin failures++;
            $display("FAIL reset_value_valid: got=%0b exp=0", bus.value_valid); end
        checks++;
        if (bus.digit_ready !== 1'b1) begin failures++;
            $display("FAIL reset_digit_ready: got=%0b exp=1", bus.digit_ready); end
        checks++;
        if (bus.value !== 14'd0 || bus.ndig !== 3'd0 || bus.err !== 1'b0) begin failures++;
            $display("FAIL reset_state: value=%0d ndig=%0d err=%0b exp=0/0/0",
                     bus.value, bus.ndig, bus.err); end
    endtask

    task automatic test_1234();
        bus.value_ready = 1'b1;
        send_digit(4'd1, 1'b0);
        send_digit(4'd2, 1'b0);
        send_digit(4'd3, 1'b0);
        checks++;
        if (bus.value !== 14'd123 || bus.ndig !== 3'd3 || bus.value_valid !== 1'b0) begin failures++;
            $display("FAIL live_123: value=%0d ndig=%0d vv=%0b exp=123/3/0",
                     bus.value, bus.ndig, bus.value_valid); end
        send_digit(4'd4, 1'b1);
        checks++;
        if (bus.value_valid !== 1'b1 || bus.value !== 14'd1234 || bus.ndig !== 3'd4 ||
            bus.err !== 1'b0 || bus.digit_ready !== 1'b0) begin failures++;
            $display("FAIL result_1234: vv=%0b value=%0d ndig=%0d err=%0b dr=%0b exp=1/1234/4/0/0",
                     bus.value_valid, bus.value, bus.ndig, bus.err, bus.digit_ready); end
        @(posedge clk); #1;
        checks++;
        if (bus.value_valid !== 1'b0 || bus.digit_ready !== 1'b1 ||
            bus.value !== 14'd0 || bus.ndig !== 3'd0) begin failures++;
            $display("FAIL after_handshake: vv=%0b dr=%0b value=%0d ndig=%0d exp=0/1/0/0",
                     bus.value_valid, bus.digit_ready, bus.value, bus.ndig); end
    endtask

    task automatic test_single();
        bus.value_ready = 1'b1;
        send_digit(4'd7, 1'b1);
        checks++;
        if (bus.value_valid !== 1'b1 || bus.value !== 14'd7 || bus.ndig !== 3'd1 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL single_7: vv=%0b value=%0d ndig=%0d err=%0b exp=1/7/1/0",
                     bus.value_valid, bus.value, bus.ndig, bus.err); end
        @(posedge clk); #1;
    endtask

    task automatic test_bad_digit();
        bus.value_ready = 1'b1;
        send_digit(4'd5, 1'b0);
        send_digit(4'hB, 1'b0);
        checks++;
        if (bus.err !== 1'b1 || bus.value !== 14'd5 || bus.ndig !== 3'd2) begin failures++;
            $display("FAIL bad_digit_live: err=%0b value=%0d ndig=%0d exp=1/5/2",
                     bus.err, bus.value, bus.ndig); end
        send_digit(4'd2, 1'b1);
        checks++;
        if (bus.value_valid !== 1'b1 || bus.err !== 1'b1 || bus.value !== 14'd52 || bus.ndig !== 3'd3) begin
            failures++;
            $display("FAIL bad_digit_result: vv=%0b err=%0b value=%0d ndig=%0d exp=1/1/52/3",
                     bus.value_valid, bus.err, bus.value, bus.ndig); end
        @(posedge clk); #1;
        checks++;
        if (bus.err !== 1'b0) begin failures++;
            $display("FAIL err_cleared: err=%0b exp=0", bus.err); end
    endtask

    task automatic test_too_many();
        bus.value_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_digit(4'd9, 1'b0);
        checks++;
        if (bus.err !== 1'b0 || bus.value !== 14'd9999 || bus.ndig !== 3'd4) begin failures++;
            $display("FAIL four_nines: err=%0b value=%0d ndig=%0d exp=0/9999/4",
                     bus.err, bus.value, bus.ndig); end
        send_digit(4'd9, 1'b1);
        checks++;
        if (bus.value_valid !== 1'b1 || bus.err !== 1'b1 || bus.value !== 14'd9999 || bus.ndig !== 3'd4) begin
            failures++;
            $display("FAIL overlong: vv=%0b err=%0b value=%0d ndig=%0d exp=1/1/9999/4",
                     bus.value_valid, bus.err, bus.value, bus.ndig); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bus.value_ready = 1'b0;
        send_digit(4'd4, 1'b0);
        send_digit(4'd2, 1'b1);
        // Offer a digit while DONE; it must be ignored.
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd5;
        bus.digit_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.value_valid !== 1'b1 || bus.value !== 14'd42 || bus.ndig !== 3'd2 ||
                bus.digit_ready !== 1'b0) begin failures++;
                $display("FAIL hold_42 cycle %0d: vv=%0b value=%0d ndig=%0d dr=%0b exp=1/42/2/0",
                         i, bus.value_valid, bus.value, bus.ndig, bus.digit_ready); end
            @(posedge clk); #1;
        end
        bus.digit_valid = 1'b0;
        bus.digit_last  = 1'b0;
        bus.value_ready = 1'b1;
        checks++;
        if (bus.value !== 14'd42 || bus.digit_ready !== 1'b0) begin failures++;
            $display("FAIL hold_42_final: value=%0d dr=%0b exp=42/0", bus.value, bus.digit_ready); end
        @(posedge clk); #1;
        checks++;
        if (bus.digit_ready !== 1'b1 || bus.value_valid !== 1'b0 || bus.value !== 14'd0) begin failures++;
            $display("FAIL release_42: dr=%0b vv=%0b value=%0d exp=1/0/0",
                     bus.digit_ready, bus.value_valid, bus.value); end
    endtask

    task automatic test_mid_reset();
        bus.value_ready = 1'b1;
        send_digit(4'd8, 1'b0);
        send_digit(4'd6, 1'b0);
        checks++;
        if (bus.value !== 14'd86 || bus.ndig !== 3'd2) begin failures++;
            $display("FAIL live_86: value=%0d ndig=%0d exp=86/2", bus.value, bus.ndig); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.value_valid !== 1'b0 || bus.value !== 14'd0 || bus.ndig !== 3'd0 || bus.digit_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: vv=%0b value=%0d ndig=%0d dr=%0b exp=0/0/0/1",
                     bus.value_valid, bus.value, bus.ndig, bus.digit_ready); end
        send_digit(4'd3, 1'b1);
        checks++;
        if (bus.value_valid !== 1'b1 || bus.value !== 14'd3 || bus.ndig !== 3'd1) begin failures++;
            $display("FAIL after_reset_3: vv=%0b value=%0d ndig=%0d exp=1/3/1",
                     bus.value_valid, bus.value, bus.ndig); end
        @(posedge clk); #1;
        // Reset while holding a result in DONE.
        bus.value_ready = 1'b0;
        send_digit(4'd6, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.value_ready = 1'b1;
        checks++;
        if (bus.value_valid !== 1'b0 || bus.value !== 14'd0 || bus.digit_ready !== 1'b1) begin failures++;
            $display("FAIL done_reset: vv=%0b value=%0d dr=%0b exp=0/0/1",
                     bus.value_valid, bus.value, bus.digit_ready); end
    endtask

    task automatic test_back_to_back();
        bus.value_ready = 1'b1;
        send_digit(4'd1, 1'b1);
        // Offer the next number immediately; DONE must refuse it this cycle.
        send_digit(4'd2, 1'b0);
        send_digit(4'd5, 1'b1);
        checks++;
        if (bus.value_valid !== 1'b1 || bus.value !== 14'd25 || bus.ndig !== 3'd2) begin failures++;
            $display("FAIL back_to_back_25: vv=%0b value=%0d ndig=%0d exp=1/25/2",
                     bus.value_valid, bus.value, bus.ndig); end
        @(posedge clk); #1;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.digit_last  = 1'b0;
        bus.value_ready = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_1234();
        test_single();
        test_bad_digit();
        test_too_many();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bcd_accumulator
`default_nettype wire

// File: doc/bcd_accumulator.md
BCD_ACCUMULATOR -- requirements
Module: bcd_accumulator

Interface
REQ-001 Parameter NDIGITS, default 4, is the maximum number of BCD digits per number.
REQ-002 Parameter BIN_W, default 14, is the binary result width; BIN_W SHALL be at least ceil(log2(10^NDIGITS)).
REQ-003 Port clk, input, 1 bit, is the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit, is the synchronous, active-high reset.
REQ-005 Port digit_valid, input, 1 bit, means the upstream stage presents a digit.
REQ-006 Port digit, input, 4 bits, is the BCD digit, most significant digit first.
REQ-007 Port digit_last, input, 1 bit, marks the final digit of a number and is qualified by digit_valid.
REQ-008 Port digit_ready, output, 1 bit, means the block accepts a digit this cycle.
REQ-009 Port value, output, BIN_W bits, is the accumulated binary value.
REQ-010 Port value_valid, output, 1 bit, means value, err and ndig are presented downstream.
REQ-011 Port value_ready, input, 1 bit, means downstream accepts the result.
REQ-012 Port err, output, 1 bit, is the input-error flag for the current number.
REQ-013 Port ndig, output, clog2(NDIGITS+1) bits, is the count of digits accepted.

Function
REQ-014 A digit is accepted on a cycle where digit_valid and digit_ready are both 1.
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE and ACCUM, digit_ready SHALL be 1; in DONE, it SHALL be 0.
REQ-017 IDLE goes to ACCUM on an accepted digit with digit_last=0, and to DONE on an accepted digit with digit_last=1.
REQ-018 ACCUM stays in ACCUM on an accepted non-last digit and goes to DONE on an accepted last digit.
REQ-019 On acceptance of a valid digit with no overflow, acc SHALL become acc*10+digit, computed as (acc<<3)+(acc<<1)+digit truncated to BIN_W bits.
REQ-020 An accepted digit greater than 9 SHALL set err, leave acc unchanged and still increment ndig.
REQ-021 An accepted digit when ndig already equals NDIGITS SHALL set err, leave acc and ndig unchanged, and still honour digit_last.
REQ-022 err SHALL be sticky until the result handshake completes.
REQ-023 value_valid SHALL be 1 exactly in DONE, asserting the cycle after the last digit is accepted, which is one cycle of latency.
REQ-024 value, err and ndig SHALL be held stable while value_valid=1 and value_ready=0.
REQ-025 In DONE with value_ready=1, the FSM returns to IDLE and acc, ndig and err are cleared.
REQ-026 After the DONE handshake, digit_ready returns to 1 on the next cycle; there is no same-cycle bypass.
REQ-027 value SHALL equal acc at all times, and ndig and err SHALL reflect the live count and flag during ACCUM.
REQ-028 digit_valid with digit_ready=0 SHALL have no effect; upstream holds the digit.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL enter IDLE with acc=0, ndig=0, err=0, value_valid=0 and digit_ready=1 in the following cycle.
REQ-030 rst SHALL take priority over every handshake, including mid-number and in DONE; partial results are discarded.

Structure
REQ-031 A package bcd_pkg SHALL hold the state enum (IDLE, ACCUM, DONE) and the constant BCD_MAX=9.
REQ-032 A combinational sub-module bcd_mac10 (inputs acc and digit; output acc*10+digit; BIN_W parameter) SHALL implement the shift-add.

Verification
REQ-033 Digits 1,2,3,4 with last on the 4th and value_ready=1 -> value_valid one cycle later, value=1234, ndig=4, err=0.
REQ-034 Single digit 7 with last=1 -> value=7, ndig=1, err=0.
REQ-035 Digits 5,0xB,2(last) -> err=1, value=52, ndig=3.
REQ-036 Digits 9,9,9,9,9(last) with NDIGITS=4 -> err=1, value=9999, ndig=4.
REQ-037 Number 42 completes with value_ready=0 for 3 cycles -> value=42 held, digit_ready=0 throughout; digit_ready=1 the cycle after value_ready=1.
REQ-038 rst=1 after digits 8,6 -> next cycle value_valid=0, value=0, ndig=0; following number 3(last) -> value=3.
